// File: rtl/mema_pkg.sv
// -----------------------------------------------------------------------------
// mema_pkg
// Shared definitions for the matrix-A read controller: default lane count and
// widths, the address-width helper and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mema_pkg;

  localparam int DEF_N      = 4;     // row-by-vector lanes
  localparam int DEF_W      = 32;    // per-lane chunk count width
  localparam int DEF_HEIGHT = 2000;  // matrix-A memory height in row groups

  // One spare bit above $clog2 so an address equal to the height is
  // representable.
  function automatic int addr_width(input int height);
    return $clog2(height) + 1;
  endfunction

  localparam int DEF_AW = addr_width(DEF_HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_FINISH     = 3'd4
  } state_e;

endpackage

// File: rtl/mema_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// mema_read_ctrl_if
// Bundles the run request, lane readiness and the memory-read side of the
// matrix-A read controller.
//   master : requester / row-by-vector side (drives start, run setup, ready)
//   slave  : the controller (drives address, read_preprocess, busy, done)
// Optional feature: MEMA_READ_CTRL_PERF_CNT_EN adds stall_cycles.
// -----------------------------------------------------------------------------
interface mema_read_ctrl_if #(
  parameter int N  = mema_pkg::DEF_N,
  parameter int W  = mema_pkg::DEF_W,
  parameter int AW = mema_pkg::DEF_AW
);

  logic            start;
  logic [AW-1:0]   base_address;
  logic [AW-1:0]   row_group_count;
  logic [N*W-1:0]  no_of_multiples;
  logic [N-1:0]    I_am_ready;
  logic [AW-1:0]   memA_read_address;
  logic            read_preprocess;
  logic            busy;
  logic            done;
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  modport master (
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
    input  stall_cycles,
`endif
    output start, base_address, row_group_count, no_of_multiples, I_am_ready,
    input  memA_read_address, read_preprocess, busy, done
  );

  modport slave (
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
    output stall_cycles,
`endif
    input  start, base_address, row_group_count, no_of_multiples, I_am_ready,
    output memA_read_address, read_preprocess, busy, done
  );

endinterface

// File: rtl/mema_read_ctrl_lane_max.sv
// -----------------------------------------------------------------------------
// lane_max_reduce
// Combinational maximum over N packed lane values; a lane value of 0 counts
// as 1, so the result is never below 1.
//   lanes_i : N*W packed lane values, lane i at [(i+1)*W-1 -: W]
//   max_o   : max over lanes, floor of 1
// -----------------------------------------------------------------------------
module lane_max_reduce #(
  parameter int N = mema_pkg::DEF_N,
  parameter int W = mema_pkg::DEF_W
) (
  input  logic [N*W-1:0] lanes_i,
  output logic [W-1:0]   max_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives max_o (no latch).
    // Seeding with 1 also makes zero-valued lanes behave as 1.
    max_o = W'(1);
    for (int i = 0; i < N; i++) begin
      if (lanes_i[i*W +: W] > max_o) max_o = lanes_i[i*W +: W];
    end
  end

endmodule

// File: rtl/mema_read_ctrl.sv
// -----------------------------------------------------------------------------
// mema_read_ctrl
// Steps the matrix-A read address through a run of row groups. For each group
// it waits until every row-by-vector lane is ready, pulses read_preprocess,
// holds the address for chunk_max*cycles_per_chunk issue cycles plus
// drain_cycles drain cycles, then moves on (wrapping at memory_A_height).
// Ports:
//   clk     : clock, everything on posedge
//   reset_n : synchronous active-low reset
//   bus     : mema_read_ctrl_if.slave (start, base_address, row_group_count,
//             no_of_multiples, I_am_ready -> memA_read_address,
//             read_preprocess, busy, done [, stall_cycles])
// Optional feature: define MEMA_READ_CTRL_PERF_CNT_EN for the stall_cycles
// counter (WAIT_READY cycles with partial readiness, saturating).
// -----------------------------------------------------------------------------
module mema_read_ctrl
  import mema_pkg::*;
#(
  parameter int no_of_row_by_vector_modules  = DEF_N,
  parameter int multiples_memory_value_width = DEF_W,
  parameter int memory_A_height              = DEF_HEIGHT,
  parameter int cycles_per_chunk             = 2,
  parameter int drain_cycles                 = 2
) (
  input logic             clk,
  input logic             reset_n,
  mema_read_ctrl_if.slave bus
);

  localparam int N             = no_of_row_by_vector_modules;
  localparam int W             = multiples_memory_value_width;
  localparam int address_width = addr_width(memory_A_height);
  // Wide enough for (2^W - 1) * cycles_per_chunk.
  localparam int CNT_W         = W + $clog2(cycles_per_chunk + 1);
  localparam int DRAIN_LOAD    = (drain_cycles > 0) ? drain_cycles - 1 : 0;
  localparam logic [address_width-1:0] LAST_ADDR =
    address_width'(memory_A_height - 1);

  state_e                   state_q;
  logic [address_width-1:0] addr_q;
  logic [address_width-1:0] groups_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     rp_q;
  logic                     busy_q;
  logic                     done_q;
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
  logic [31:0]              stall_q;
`endif

  logic [W-1:0]             chunk_max;
  logic [CNT_W-1:0]         issue_len_d;
  logic [address_width-1:0] addr_inc_d;
  logic                     all_ready;

  lane_max_reduce #(.N(N), .W(W)) u_lane_max (
    .lanes_i (bus.no_of_multiples),
    .max_o   (chunk_max)
  );

  // Issue counter counts down to 0, so load length-1; chunk_max >= 1 keeps
  // this from underflowing.
  assign issue_len_d = CNT_W'(chunk_max) * CNT_W'(cycles_per_chunk) - CNT_W'(1);
  assign addr_inc_d  = (addr_q >= LAST_ADDR) ? '0 : addr_q + address_width'(1);
  assign all_ready   = &bus.I_am_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      groups_q <= '0;
      cnt_q    <= '0;
      rp_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
      stall_q  <= '0;
`endif
    end else begin
      rp_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
            stall_q <= '0;
`endif
            if (bus.row_group_count != '0) begin
              addr_q   <= bus.base_address;
              groups_q <= bus.row_group_count;
              busy_q   <= 1'b1;
              state_q  <= ST_WAIT_READY;
            end else begin
              // Empty run: report completion without ever going busy.
              done_q <= 1'b1;
            end
          end
        end
        ST_WAIT_READY: begin
          if (all_ready) begin
            rp_q    <= 1'b1;
            cnt_q   <= issue_len_d;  // chunk_max frozen here for the group
            state_q <= ST_ISSUE;
          end
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
          else if (stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
          end
`endif
        end
        ST_ISSUE: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(DRAIN_LOAD);
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            if (groups_q > address_width'(1)) begin
              groups_q <= groups_q - address_width'(1);
              addr_q   <= addr_inc_d;
              state_q  <= ST_WAIT_READY;
            end else begin
              groups_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_FINISH;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.memA_read_address = addr_q;
  assign bus.read_preprocess   = rp_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
  assign bus.stall_cycles      = stall_q;
`endif

endmodule

// File: tb/tb_mema_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mema_read_ctrl
// Directed bench for mema_read_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Cycle 0 of a capture is the first
// falling edge after the rising edge that sampled start.
// -----------------------------------------------------------------------------
module tb_mema_read_ctrl;

  localparam int N      = 4;
  localparam int W      = 32;
  localparam int HEIGHT = 2000;
  localparam int AW     = 12;
  localparam int CPC    = 2;
  localparam int DRAIN  = 2;

  logic clk;
  logic reset_n;

  mema_read_ctrl_if #(.N(N), .W(W), .AW(AW)) bus ();

  mema_read_ctrl #(
    .no_of_row_by_vector_modules  (N),
    .multiples_memory_value_width (W),
    .memory_A_height              (HEIGHT),
    .cycles_per_chunk             (CPC),
    .drain_cycles                 (DRAIN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [AW-1:0] cap_addr [256];
  logic          cap_busy [256];
  int            rp_cyc   [8];
  int            n_rp, n_done, done_cyc, cap_len;

  function automatic logic [N*W-1:0] pack4(input int l3, l2, l1, l0);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic logic [AW-1:0] addr_at_rp(input int k);
    if (k < n_rp && k < 8 && rp_cyc[k] >= 0) return cap_addr[rp_cyc[k]];
    return 'x;
  endfunction

  task automatic drive_idle();
    bus.start           = 1'b0;
    bus.base_address    = '0;
    bus.row_group_count = '0;
    bus.no_of_multiples = '0;
    bus.I_am_ready      = '1;
  endtask

  task automatic launch(input int base, input int cnt);
    bus.base_address    = AW'(base);
    bus.row_group_count = AW'(cnt);
    bus.start           = 1'b1;
  endtask

  // act_kind: 0 none, 1 multiples -> all 9, 2 ready -> all ones,
  //           3 one-cycle start with base=7 count=5
  task automatic capture(input int max_cyc, input int act_cyc, input int act_kind);
    n_rp = 0; n_done = 0; done_cyc = -1; cap_len = 0;
    for (int k = 0; k < 8; k++) rp_cyc[k] = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == 0) bus.start = 1'b0;
      cap_addr[c] = bus.memA_read_address;
      cap_busy[c] = bus.busy;
      cap_len     = c + 1;
      if (bus.read_preprocess === 1'b1) begin
        if (n_rp < 8) rp_cyc[n_rp] = c;
        n_rp++;
      end
      if (bus.done === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        n_done++;
      end
      if (c == act_cyc) begin
        case (act_kind)
          1: bus.no_of_multiples = pack4(9, 9, 9, 9);
          2: bus.I_am_ready = '1;
          3: begin
            bus.start           = 1'b1;
            bus.base_address    = AW'(7);
            bus.row_group_count = AW'(5);
          end
          default: ;
        endcase
      end
      if (act_kind == 3 && c == act_cyc + 1) bus.start = 1'b0;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.memA_read_address !== '0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", bus.memA_read_address); end
    tests_run++;
    if (bus.read_preprocess !== 1'b0) begin tests_failed++; $display("FAIL reset_rp: got %b expected 0", bus.read_preprocess); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
    tests_run++;
    if (bus.stall_cycles !== 32'd0) begin tests_failed++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cycles); end
`endif
    // Release reset and request on the same edge: must be accepted there.
    reset_n = 1'b1;
    bus.no_of_multiples = pack4(1, 1, 1, 1);
    launch(3, 1);
    capture(40, -1, 0);
    tests_run++;
    if (cap_busy[0] !== 1'b1) begin tests_failed++; $display("FAIL first_start_busy: got %b expected 1", cap_busy[0]); end
    tests_run++;
    if (addr_at_rp(0) !== AW'(3)) begin tests_failed++; $display("FAIL first_start_addr: got %0d expected 3", addr_at_rp(0)); end
    tests_run++;
    if (done_cyc !== 5) begin tests_failed++; $display("FAIL first_start_done_cycle: got %0d expected 5", done_cyc); end
  endtask

  task automatic test_basic_run();
    int hold_bad, busy_bad;
    bus.no_of_multiples = pack4(3, 3, 3, 3);
    bus.I_am_ready      = '1;
    launch(5, 3);
    capture(80, -1, 0);
    tests_run++;
    if (n_rp !== 3) begin tests_failed++; $display("FAIL basic_rp_count: got %0d expected 3", n_rp); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (addr_at_rp(k) !== AW'(5 + k)) begin tests_failed++; $display("FAIL basic_addr_%0d: got %0d expected %0d", k, addr_at_rp(k), 5 + k); end
    end
    tests_run++;
    if (rp_cyc[2] !== 19) begin tests_failed++; $display("FAIL basic_rp3_cycle: got %0d expected 19", rp_cyc[2]); end
    hold_bad = 0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 8; j++)
        if (rp_cyc[k] < 0 || rp_cyc[k] + j >= cap_len || cap_addr[rp_cyc[k] + j] !== AW'(5 + k)) hold_bad++;
    tests_run++;
    if (hold_bad !== 0) begin tests_failed++; $display("FAIL basic_addr_hold: got %0d unstable cycles expected 0", hold_bad); end
    tests_run++;
    if (done_cyc !== 27) begin tests_failed++; $display("FAIL basic_done_cycle: got %0d expected 27", done_cyc); end
    tests_run++;
    if (n_done !== 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
    busy_bad = 0;
    for (int c = 0; c < 27 && c < cap_len; c++) if (cap_busy[c] !== 1'b1) busy_bad++;
    if (cap_len > 27 && cap_busy[27] !== 1'b0) busy_bad++;
    tests_run++;
    if (busy_bad !== 0) begin tests_failed++; $display("FAIL basic_busy_window: got %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_chunk_max();
    // Lanes {1,4,0,2}: max 4 -> 8 issue cycles; change at cycle 2 must not count.
    bus.no_of_multiples = pack4(2, 0, 4, 1);
    launch(20, 1);
    capture(80, 2, 1);
    tests_run++;
    if (rp_cyc[0] !== 1) begin tests_failed++; $display("FAIL chunk_rp_cycle: got %0d expected 1", rp_cyc[0]); end
    tests_run++;
    if (done_cyc !== 11) begin tests_failed++; $display("FAIL chunk_done_cycle: got %0d expected 11", done_cyc); end
    tests_run++;
    if (addr_at_rp(0) !== AW'(20)) begin tests_failed++; $display("FAIL chunk_addr: got %0d expected 20", addr_at_rp(0)); end
  endtask

  task automatic test_partial_ready();
    bus.no_of_multiples = pack4(1, 1, 1, 1);
    bus.I_am_ready      = 4'b0111;
    launch(30, 1);
    capture(80, 10, 2);
    tests_run++;
    if (rp_cyc[0] !== 11) begin tests_failed++; $display("FAIL stall_rp_cycle: got %0d expected 11", rp_cyc[0]); end
    tests_run++;
    if (done_cyc !== 15) begin tests_failed++; $display("FAIL stall_done_cycle: got %0d expected 15", done_cyc); end
    tests_run++;
    if (addr_at_rp(0) !== AW'(30)) begin tests_failed++; $display("FAIL stall_addr: got %0d expected 30", addr_at_rp(0)); end
`ifdef MEMA_READ_CTRL_PERF_CNT_EN
    tests_run++;
    if (bus.stall_cycles !== 32'd10) begin tests_failed++; $display("FAIL stall_count: got %0d expected 10", bus.stall_cycles); end
`endif
  endtask

  task automatic test_zero_count();
    launch(9, 0);
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL zero_done_pulse: got %b expected 1", bus.done); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_c0: got %b expected 0", bus.busy); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL zero_done_clear: got %b expected 0", bus.done); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_c1: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bus.no_of_multiples = pack4(3, 3, 3, 3);
    launch(10, 3);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) bus.start = 1'b0;
      if (bus.read_preprocess === 1'b1) seen++;
      if (seen == 2) break;
    end
    tests_run++;
    if (seen !== 2) begin tests_failed++; $display("FAIL midrst_second_group: got %0d pulses expected 2", seen); end
    tests_run++;
    if (bus.memA_read_address !== AW'(11)) begin tests_failed++; $display("FAIL midrst_group2_addr: got %0d expected 11", bus.memA_read_address); end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.memA_read_address, bus.read_preprocess, bus.busy, bus.done} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got addr=%0d rp=%b busy=%b done=%b expected all 0",
               bus.memA_read_address, bus.read_preprocess, bus.busy, bus.done);
    end
    reset_n = 1'b1;
    bus.no_of_multiples = pack4(1, 1, 1, 1);
    launch(0, 1);
    capture(40, -1, 0);
    tests_run++;
    if (cap_busy[0] !== 1'b1) begin tests_failed++; $display("FAIL midrst_restart_busy: got %b expected 1", cap_busy[0]); end
    tests_run++;
    if (addr_at_rp(0) !== AW'(0)) begin tests_failed++; $display("FAIL midrst_restart_addr: got %0d expected 0", addr_at_rp(0)); end
    tests_run++;
    if (done_cyc !== 5) begin tests_failed++; $display("FAIL midrst_restart_done: got %0d expected 5", done_cyc); end
  endtask

  task automatic test_wrap_and_ignore();
    bus.no_of_multiples = pack4(1, 1, 1, 1);
    launch(HEIGHT, 2);
    capture(80, 2, 3);
    tests_run++;
    if (n_rp !== 2) begin tests_failed++; $display("FAIL wrap_rp_count: got %0d expected 2", n_rp); end
    tests_run++;
    if (addr_at_rp(0) !== AW'(HEIGHT)) begin tests_failed++; $display("FAIL wrap_first_addr: got %0d expected %0d", addr_at_rp(0), HEIGHT); end
    tests_run++;
    if (addr_at_rp(1) !== AW'(0)) begin tests_failed++; $display("FAIL wrap_second_addr: got %0d expected 0", addr_at_rp(1)); end
    tests_run++;
    if (rp_cyc[1] !== 6) begin tests_failed++; $display("FAIL wrap_rp2_cycle: got %0d expected 6", rp_cyc[1]); end
    tests_run++;
    if (done_cyc !== 10) begin tests_failed++; $display("FAIL wrap_done_cycle: got %0d expected 10", done_cyc); end
    tests_run++;
    if (n_done !== 1) begin tests_failed++; $display("FAIL wrap_done_count: got %0d expected 1", n_done); end
    tests_run++;
    if (cap_len < 14 || cap_busy[13] !== 1'b0) begin tests_failed++; $display("FAIL wrap_idle_after: got busy=%b expected 0", cap_busy[13]); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_chunk_max();
    test_partial_ready();
    test_zero_count();
    test_reset_mid_run();
    test_wrap_and_ignore();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
